// File: rtl/pdm_injector_pkg.sv
// Shared types and constants for the PDM injector transmitter.
package pdm_injector_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned OSR_W_DEF = 8;

  // Signed zero maps to offset-binary midscale (50 % density).
  localparam int MIDSCALE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pdm_sd1_mod.sv
// First-order delta-sigma modulator; owns the accumulator and the inp/inn flops.
module pdm_sd1_mod #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] x,
  output logic          inp,
  output logic          inn
);

  logic [DW-1:0] acc;
  logic [DW-1:0] u;
  logic [DW:0]   sum;

  // Offset-binary input: flipping the sign bit maps signed x onto 0..2^DW-1.
  always_comb begin
    u         = x;
    u[DW-1]   = ~x[DW-1];
    sum       = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      inp <= 1'b0;
      inn <= 1'b1;
    end else begin
      acc <= sum[DW-1:0];
      inp <= sum[DW];
      inn <= ~sum[DW];
    end
  end

endmodule

// File: rtl/pdm_injector_tx.sv
// Sample stream front end: holds each accepted sample for osr clocks and feeds the modulator.
module pdm_injector_tx
  import pdm_injector_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned OSR_W = OSR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OSR_W-1:0] osr,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             inp,
  output logic             inn,
  output logic             busy,
  output logic             underrun,
  input  logic             clr_underrun
);

  state_e           state, state_n;
  logic [OSR_W-1:0] cnt, cnt_n;
  logic [OSR_W-1:0] osr_eff;
  logic [DW-1:0]    cur, cur_n;
  logic [DW-1:0]    x;
  logic             underrun_n;
  logic             boundary;

  assign osr_eff  = (osr == '0) ? OSR_W'(1) : osr;
  assign boundary = (cnt == (osr_eff - OSR_W'(1)));
  assign s_ready  = (state == FILL) || ((state == RUN) && boundary);
  assign busy     = (state != IDLE);
  assign x        = (state == RUN) ? cur : DW'(MIDSCALE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cur      <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur      <= cur_n;
      underrun <= underrun_n;
    end
  end

  // en outranks s_valid; an underrun set outranks a simultaneous clear.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cur_n      = cur;
    underrun_n = underrun & ~clr_underrun;
    case (state)
      IDLE: begin
        if (en) state_n = FILL;
      end
      FILL: begin
        if (!en) begin
          state_n = IDLE;
        end else if (s_valid) begin
          cur_n   = s_data;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          cur_n   = '0;
          cnt_n   = '0;
        end else if (boundary) begin
          cnt_n = '0;
          if (s_valid) begin
            cur_n = s_data;
          end else begin
            cur_n      = '0;
            underrun_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + OSR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cur_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  pdm_sd1_mod #(.DW(DW)) u_mod (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .inp   (inp),
    .inn   (inn)
  );

endmodule
